// File: rtl/seq_div_ctrl.sv
// rtl/seq_div_ctrl.sv - multi-cycle restoring divider controller with signed/unsigned support
module seq_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_div_zero,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_signed;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;

    logic [WIDTH-1:0] r_out_q;
    logic [WIDTH-1:0] r_out_r;
    logic             r_out_dz;
    logic             r_out_valid;

    logic             w_accept;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic             w_div_zero;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_sub;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    assign in_ready      = (r_state == S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign out_valid     = r_out_valid;
    assign out_quotient  = r_out_q;
    assign out_remainder = r_out_r;
    assign out_div_zero  = r_out_dz;

    assign w_accept   = in_valid && (r_state == S_IDLE);
    assign w_dvd_neg  = in_signed && in_dividend[WIDTH-1];
    assign w_dvs_neg  = in_signed && in_divisor[WIDTH-1];
    assign w_div_zero = (in_divisor == '0);

    // Magnitudes are WIDTH-bit unsigned, so the most negative value maps to 2^(WIDTH-1).
    assign w_dvd_mag = w_dvd_neg ? (~in_dividend + ONE) : in_dividend;
    assign w_dvs_mag = w_dvs_neg ? (~in_divisor + ONE) : in_divisor;

    // One restoring step: the shifted remainder can need WIDTH+1 bits before the compare.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_dvs});
    assign w_sub      = w_shift - {1'b0, r_dvs};
    assign w_rem_next = w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};

    // Sign correction; quotient wraps naturally for the most-negative / -1 case.
    assign w_q_fix = (r_signed && r_neg_q) ? (~r_quo + ONE) : r_quo;
    assign w_r_fix = (r_signed && r_neg_r) ? (~r_rem + ONE) : r_rem;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; divide by zero skips CALC but still passes through FIXUP.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_div_zero ? S_FIXUP : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == '0) begin
                    w_next = S_FIXUP;
                end
            end
            S_FIXUP: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand latch, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_signed    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dz        <= 1'b0;
            r_out_q     <= '0;
            r_out_r     <= '0;
            r_out_dz    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_signed <= in_signed;
                        r_neg_q  <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r  <= w_dvd_neg;
                        r_dz     <= w_div_zero;
                        r_dvs    <= w_dvs_mag;
                        r_rem    <= '0;
                        r_cnt    <= CNT_LAST;
                        // A zero divisor returns the raw dividend as remainder, so keep it unconverted.
                        r_quo    <= w_div_zero ? in_dividend : w_dvd_mag;
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_FIXUP: begin
                    r_out_valid <= 1'b1;
                    r_out_dz    <= r_dz;
                    if (r_dz) begin
                        r_out_q <= '1;
                        r_out_r <= r_quo;
                    end else begin
                        r_out_q <= w_q_fix;
                        r_out_r <= w_r_fix;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_ctrl.sv
// tb/tb_seq_div_ctrl.sv - directed self-checking bench for seq_div_ctrl at WIDTH=8
module tb_seq_div_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_signed;
    logic [W-1:0] in_dividend;
    logic [W-1:0] in_divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_quotient;
    logic [W-1:0] out_remainder;
    logic         out_div_zero;
    logic         busy;

    int n_cmp;
    int n_fail;

    seq_div_ctrl #(.WIDTH(W)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_signed    (in_signed),
        .in_dividend  (in_dividend),
        .in_divisor   (in_divisor),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quotient (out_quotient),
        .out_remainder(out_remainder),
        .out_div_zero (out_div_zero),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b want=0", busy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (out_quotient !== 8'h00) begin n_fail++; $display("FAIL rst_q got=%h want=00", out_quotient); end
        n_cmp++; if (out_remainder !== 8'h00) begin n_fail++; $display("FAIL rst_r got=%h want=00", out_remainder); end
        n_cmp++; if (out_div_zero !== 1'b0) begin n_fail++; $display("FAIL rst_dz got=%b want=0", out_div_zero); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one operation end to end; hold > 0 keeps out_ready low that many cycles in DONE.
    task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                          input logic exp_dz, input int exp_lat, input int hold,
                          input string name);
        int lat;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s in_ready_pre got=%b want=1", name, in_ready); end
        in_signed   = sgn;
        in_dividend = a;
        in_divisor  = b;
        in_valid    = 1'b1;
        out_ready   = (hold == 0);
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        in_dividend = 8'hAA;
        in_divisor  = 8'h55;
        in_signed   = ~sgn;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_after_accept got=%b want=1", name, busy); end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_cmp++; if (lat != exp_lat) begin n_fail++; $display("FAIL %s latency got=%0d want=%0d", name, lat, exp_lat); end
        n_cmp++; if (out_quotient !== exp_q) begin n_fail++; $display("FAIL %s quotient got=%h want=%h", name, out_quotient, exp_q); end
        n_cmp++; if (out_remainder !== exp_r) begin n_fail++; $display("FAIL %s remainder got=%h want=%h", name, out_remainder, exp_r); end
        n_cmp++; if (out_div_zero !== exp_dz) begin n_fail++; $display("FAIL %s div_zero got=%b want=%b", name, out_div_zero, exp_dz); end
        for (int i = 0; i < hold; i++) begin
            in_valid    = 1'b1;
            in_dividend = 8'h11;
            in_divisor  = 8'h01;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s bp_valid[%0d] got=%b want=1", name, i, out_valid); end
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL %s bp_in_ready[%0d] got=%b want=0", name, i, in_ready); end
            n_cmp++; if (out_quotient !== exp_q) begin n_fail++; $display("FAIL %s bp_q[%0d] got=%h want=%h", name, i, out_quotient, exp_q); end
            n_cmp++; if (out_remainder !== exp_r) begin n_fail++; $display("FAIL %s bp_r[%0d] got=%h want=%h", name, i, out_remainder, exp_r); end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s valid_after_hs got=%b want=0", name, out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s in_ready_after_hs got=%b want=1", name, in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_after_hs got=%b want=0", name, busy); end
        n_cmp++; if (out_quotient !== exp_q) begin n_fail++; $display("FAIL %s q_held_idle got=%h want=%h", name, out_quotient, exp_q); end
    endtask

    task automatic test_signed();
        run_op(1'b1, 8'hF4, 8'h03, 8'hFC, 8'h00, 1'b0, 9, 0, "s_m12_3");
        run_op(1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 9, 0, "s_m7_2");
        run_op(1'b1, 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 9, 0, "s_7_m2");
    endtask

    task automatic test_unsigned();
        run_op(1'b0, 8'hF4, 8'h03, 8'h51, 8'h01, 1'b0, 9, 0, "u_244_3");
        run_op(1'b0, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 9, 0, "u_255_1");
    endtask

    task automatic test_overflow_edge();
        run_op(1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 9, 0, "s_min_m1");
        run_op(1'b0, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 9, 0, "u_128_255");
    endtask

    task automatic test_div_zero();
        run_op(1'b0, 8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 1, 0, "u_dz");
        run_op(1'b1, 8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 1, 0, "s_dz");
        run_op(1'b1, 8'hF4, 8'h00, 8'hFF, 8'hF4, 1'b1, 1, 0, "s_dz_neg");
        run_op(1'b0, 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 9, 0, "after_dz");
    endtask

    task automatic test_backpressure();
        run_op(1'b0, 8'hC8, 8'h0A, 8'h14, 8'h00, 1'b0, 9, 5, "bp_200_10");
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        in_signed   = 1'b1;
        in_dividend = 8'hF4;
        in_divisor  = 8'h03;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b want=0", busy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%b want=0", out_valid); end
        n_cmp++; if (out_quotient !== 8'h00) begin n_fail++; $display("FAIL midrst_q got=%h want=00", out_quotient); end
        n_cmp++; if (out_remainder !== 8'h00) begin n_fail++; $display("FAIL midrst_r got=%h want=00", out_remainder); end
        n_cmp++; if (out_div_zero !== 1'b0) begin n_fail++; $display("FAIL midrst_dz got=%b want=0", out_div_zero); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_result got=%b want=0", out_valid); end
        run_op(1'b0, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9, 0, "u_100_7");
    endtask

    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_signed   = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        out_ready   = 1'b1;
        test_reset();
        test_signed();
        test_unsigned();
        test_overflow_edge();
        test_div_zero();
        test_backpressure();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
